// File: rtl/button_step_gen_pkg.sv
// Shared definitions for the button step generator: FSM encodings, button
// polarity and the cycle-count defaults derived from the board clock.
package button_step_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_INC = 2'd1,
    ST_HOLD_DEC = 2'd2,
    ST_LOCK     = 2'd3
  } state_t;

  localparam logic BTN_PRESSED = 1'b0;

  localparam int CLK_HZ                = 12_000_000;
  localparam int DEBOUNCE_DEFAULT      = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_DEFAULT  = CLK_HZ / 2;    // 0.5 s
  localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;   // 0.1 s

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_step_gen_btn_debounce.sv
// One button channel: 2-FF synchronizer, consecutive-mismatch debounce
// counter and the accepted (debounced) level.
module button_step_gen_btn_debounce
  import button_step_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      // The Nth consecutive mismatching sample flips the level directly,
      // so the counter never has to hold DEBOUNCE_CYCLES itself.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign pressed = (level == BTN_PRESSED);

endmodule

// File: rtl/button_step_gen.sv
// Turns two debounced push buttons into single-cycle inc/dec step pulses
// with hold-to-repeat and rejection of simultaneous presses.
module button_step_gen
  import button_step_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc_n,
  input  logic btn_dec_n,
  output logic inc,
  output logic dec,
  output logic busy
);

  localparam int TIMER_W =
    $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;

  logic               p_inc;
  logic               p_dec;
  state_t             state;
  logic [TIMER_W-1:0] timer;

  button_step_gen_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_inc_n),
    .pressed(p_inc)
  );

  button_step_gen_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_dec_n),
    .pressed(p_dec)
  );

  // Release is tested before the timer, so a repeat falling due on the
  // cycle the release is accepted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      inc   <= 1'b0;
      dec   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (p_inc && p_dec) begin
            state <= ST_LOCK;
            busy  <= 1'b1;
          end else if (p_inc) begin
            state <= ST_HOLD_INC;
            busy  <= 1'b1;
            inc   <= 1'b1;
            timer <= TIMER_W'(REPEAT_DELAY_CYCLES);
          end else if (p_dec) begin
            state <= ST_HOLD_DEC;
            busy  <= 1'b1;
            dec   <= 1'b1;
            timer <= TIMER_W'(REPEAT_DELAY_CYCLES);
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_HOLD_INC: begin
          if (!p_inc) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (p_dec) begin
            state <= ST_LOCK;
          end else if (timer == TIMER_W'(1)) begin
            inc   <= 1'b1;
            timer <= TIMER_W'(REPEAT_PERIOD_CYCLES);
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_HOLD_DEC: begin
          if (!p_dec) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (p_inc) begin
            state <= ST_LOCK;
          end else if (timer == TIMER_W'(1)) begin
            dec   <= 1'b1;
            timer <= TIMER_W'(REPEAT_PERIOD_CYCLES);
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        ST_LOCK: begin
          if (!p_inc && !p_dec) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: directed scenarios with fixed
// expected pulse times, then random button activity against a reference model.
module tb_button_step_gen;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int HIST = 64;

  localparam int M_IDLE = 0;
  localparam int M_HI   = 1;
  localparam int M_HD   = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc_n = 1'b1;
  logic btn_dec_n = 1'b1;
  logic inc, dec, busy;

  button_step_gen #(
    .DEBOUNCE_CYCLES     (DEB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_inc_n(btn_inc_n),
    .btn_dec_n(btn_dec_n),
    .inc      (inc),
    .dec      (dec),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: raw history per button, a level is accepted after DEB
  // consecutive synchronized samples disagree with it; repeats are scheduled
  // by absolute due edge.
  logic   m_raw[2][HIST];
  logic   m_acc[2];
  int     m_since[2];
  int     m_edge  = 0;
  int     m_first = 1;
  int     m_mode  = M_IDLE;
  longint m_due   = 0;
  logic   m_inc = 1'b0, m_dec = 1'b0, m_busy = 1'b0;

  function automatic logic syn_at(input int ch, input int e);
    if (e - 2 < m_first) return 1'b1;
    return m_raw[ch][(e - 2) % HIST];
  endfunction

  initial begin
    logic pi, pd, flip;
    m_acc[0] = 1'b1; m_acc[1] = 1'b1;
    m_since[0] = 0;  m_since[1] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_first = m_edge + 1;
        m_acc[0] = 1'b1; m_acc[1] = 1'b1;
        m_since[0] = 0;  m_since[1] = 0;
        m_mode = M_IDLE;
        m_inc = 1'b0; m_dec = 1'b0; m_busy = 1'b0;
      end else begin
        m_edge++;
        m_raw[0][m_edge % HIST] = btn_inc_n;
        m_raw[1][m_edge % HIST] = btn_dec_n;
        pi = (m_acc[0] == 1'b0);
        pd = (m_acc[1] == 1'b0);
        m_inc = 1'b0;
        m_dec = 1'b0;
        case (m_mode)
          M_IDLE: begin
            if (pi && pd) m_mode = M_LOCK;
            else if (pi) begin m_mode = M_HI; m_inc = 1'b1; m_due = m_edge + RD; end
            else if (pd) begin m_mode = M_HD; m_dec = 1'b1; m_due = m_edge + RD; end
          end
          M_HI: begin
            if (!pi) m_mode = M_IDLE;
            else if (pd) m_mode = M_LOCK;
            else if (m_edge == m_due) begin m_inc = 1'b1; m_due = m_edge + RP; end
          end
          M_HD: begin
            if (!pd) m_mode = M_IDLE;
            else if (pi) m_mode = M_LOCK;
            else if (m_edge == m_due) begin m_dec = 1'b1; m_due = m_edge + RP; end
          end
          default: if (!pi && !pd) m_mode = M_IDLE;
        endcase
        m_busy = (m_mode != M_IDLE);
        for (int ch = 0; ch < 2; ch++) begin
          m_since[ch]++;
          flip = (m_since[ch] >= DEB);
          for (int k = 0; k < DEB; k++)
            if (syn_at(ch, m_edge - k) == m_acc[ch]) flip = 1'b0;
          if (flip) begin
            m_acc[ch]   = ~m_acc[ch];
            m_since[ch] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison and pulse logging, sampled on the falling edge.
  int   base = 0;
  bit   log_en = 1'b0;
  int   inc_log[$];
  int   dec_log[$];
  int   exp_q[$];
  logic busy_log[256];
  logic prev_inc = 1'b0, prev_dec = 1'b0;

  initial begin
    int rel;
    forever begin
      @(negedge clk);
      check("inc_vs_model", inc, m_inc);
      check("dec_vs_model", dec, m_dec);
      check("busy_vs_model", busy, m_busy);
      check("inc_dec_overlap", inc & dec, 0);
      check("double_pulse", (inc & prev_inc) | (dec & prev_dec), 0);
      prev_inc = inc;
      prev_dec = dec;
      if (log_en) begin
        rel = cyc - base;
        if (inc) inc_log.push_back(rel);
        if (dec) dec_log.push_back(rel);
        if (rel >= 0 && rel < 256) busy_log[rel] = busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scenario();
    step();
    base = cyc;
    inc_log.delete();
    dec_log.delete();
    for (int i = 0; i < 256; i++) busy_log[i] = 1'bx;
    log_en = 1'b1;
  endtask

  task automatic go_to(input int rel);
    while (cyc - base < rel) step();
  endtask

  task automatic check_inc_log(input string tag);
    check({tag, "_count"}, inc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < inc_log.size(); i++)
      check({tag, "_cycle"}, inc_log[i], exp_q[i]);
  endtask

  initial begin
    int n_busy, len_i, len_d;

    repeat (3) @(posedge clk);
    #1;
    check("reset_inc", inc, 0);
    check("reset_dec", dec, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) step();

    // Single press
    start_scenario();
    btn_inc_n = 1'b0;
    go_to(10);
    btn_inc_n = 1'b1;
    go_to(30);
    log_en = 1'b0;
    exp_q = '{7};
    check_inc_log("single_inc");
    check("single_dec_count", dec_log.size(), 0);
    check("single_busy_16", busy_log[16], 1);
    check("single_busy_17", busy_log[17], 0);

    // Bounce rejection
    start_scenario();
    for (int r = 0; r < 30; r++) begin
      btn_dec_n = ((r / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    btn_dec_n = 1'b1;
    go_to(45);
    log_en = 1'b0;
    n_busy = 0;
    for (int r = 0; r <= 45; r++) if (busy_log[r] === 1'b1) n_busy++;
    check("bounce_inc_count", inc_log.size(), 0);
    check("bounce_dec_count", dec_log.size(), 0);
    check("bounce_busy_cycles", n_busy, 0);

    // Auto-repeat
    start_scenario();
    btn_inc_n = 1'b0;
    go_to(60);
    btn_inc_n = 1'b1;
    go_to(100);
    log_en = 1'b0;
    exp_q = '{7, 27, 35, 43, 51, 59};
    check_inc_log("repeat_inc");
    check("repeat_dec_count", dec_log.size(), 0);
    check("repeat_busy_66", busy_log[66], 1);
    check("repeat_busy_67", busy_log[67], 0);

    // Both buttons together
    start_scenario();
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    go_to(15);
    btn_inc_n = 1'b1;
    go_to(30);
    btn_dec_n = 1'b1;
    go_to(50);
    log_en = 1'b0;
    check("both_inc_count", inc_log.size(), 0);
    check("both_dec_count", dec_log.size(), 0);
    check("both_busy_6", busy_log[6], 0);
    check("both_busy_7", busy_log[7], 1);
    check("both_busy_29", busy_log[29], 1);
    check("both_busy_45", busy_log[45], 0);

    // Cross-press
    start_scenario();
    btn_inc_n = 1'b0;
    go_to(12);
    btn_dec_n = 1'b0;
    go_to(40);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    go_to(60);
    log_en = 1'b0;
    exp_q = '{7};
    check_inc_log("cross_inc");
    check("cross_dec_count", dec_log.size(), 0);
    check("cross_busy_30", busy_log[30], 1);
    check("cross_busy_55", busy_log[55], 0);

    // Reset mid-hold
    start_scenario();
    btn_inc_n = 1'b0;
    go_to(30);
    rst_n = 1'b0;
    #1;
    check("async_rst_inc", inc, 0);
    check("async_rst_dec", dec, 0);
    check("async_rst_busy", busy, 0);
    go_to(32);
    rst_n = 1'b1;
    go_to(50);
    btn_inc_n = 1'b1;
    go_to(70);
    log_en = 1'b0;
    exp_q = '{7, 27, 39};
    check_inc_log("rstmid_inc");
    check("rstmid_dec_count", dec_log.size(), 0);
    check("rstmid_busy_31", busy_log[31], 0);
    check("rstmid_busy_40", busy_log[40], 1);

    // Random activity against the model
    len_i = 0;
    len_d = 0;
    for (int c = 0; c < 4000; c++) begin
      if (len_i == 0) begin
        btn_inc_n = 1'($urandom_range(0, 1));
        len_i = $urandom_range(1, 60);
      end
      if (len_d == 0) begin
        btn_dec_n = 1'($urandom_range(0, 1));
        len_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : $urandom_range(1, 6);
      end
      len_i--;
      len_d--;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        rst_n = 1'b1;
      end
      step();
    end
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    repeat (20) step();
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
